alu_issue_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that directly feeds the execute-stage ALU.
- Decodes RV32I opcode/funct3/funct7[5] into the ALU's 4-bit function code.
- Selects and forwards operand values, then registers function code, op1, op2 and destination tag behind a valid/ready handshake with stall and flush.

---
 rtl/alu_issue_if.sv | 69 ++++++
 rtl/alu_issue_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Bundle of every handshake/data signal between the decode stage, the
// alu_issue_stage register and the execute-stage ALU.
//   slave  : view used by alu_issue_stage (consumes decode, produces ALU side)
//   master : view used by whoever drives decode inputs / consumes ALU side
// Signals:
//   in_valid/in_ready              decode-side handshake
//   opcode/funct3/funct7_5         instruction fields
//   rs1_idx/rs2_idx/rd_idx         register indices
//   rs1_data/rs2_data/imm/pc       operand sources
//   fwd_ex_* / fwd_wb_*            forwarding sources (EX/MEM, MEM/WB)
//   flush                          kill held and incoming instruction
//   out_valid/out_ready            ALU-side handshake
//   alu_func/alu_op1/alu_op2       registered ALU command
//   rd_out/rs2_fwd_out/illegal     registered destination, store data, flag
// ---------------------------------------------------------------------------
interface alu_issue_if #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic                    funct7_5;
    logic [RegAddrWidth-1:0] rs1_idx;
    logic [RegAddrWidth-1:0] rs2_idx;
    logic [RegAddrWidth-1:0] rd_idx;
    logic [DataWidth-1:0]    rs1_data;
    logic [DataWidth-1:0]    rs2_data;
    logic [DataWidth-1:0]    imm;
    logic [DataWidth-1:0]    pc;
    logic                    fwd_ex_valid;
    logic [RegAddrWidth-1:0] fwd_ex_rd;
    logic [DataWidth-1:0]    fwd_ex_data;
    logic                    fwd_wb_valid;
    logic [RegAddrWidth-1:0] fwd_wb_rd;
    logic [DataWidth-1:0]    fwd_wb_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              alu_func;
    logic [DataWidth-1:0]    alu_op1;
    logic [DataWidth-1:0]    alu_op2;
    logic [RegAddrWidth-1:0] rd_out;
    logic [DataWidth-1:0]    rs2_fwd_out;
    logic                    illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_idx, rs2_idx, rd_idx,
               rs1_data, rs2_data, imm, pc,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
               flush, out_ready,
        output in_ready, out_valid, alu_func, alu_op1, alu_op2, rd_out,
               rs2_fwd_out, illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_idx, rs2_idx, rd_idx,
               rs1_data, rs2_data, imm, pc,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
               flush, out_ready,
        input  in_ready, out_valid, alu_func, alu_op1, alu_op2, rd_out,
               rs2_fwd_out, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX pipeline register feeding the execute-stage ALU. Decodes RV32I
// opcode/funct3/funct7[5] into a 4-bit ALU function code, selects operands
// (with optional EX/MEM and MEM/WB forwarding) and registers the result
// behind a valid/ready handshake with flush.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (all outputs cleared)
//   bus    alu_issue_if.slave: decode inputs, forwarding sources, flush,
//          ALU-side registered outputs and both handshakes
//
// Configuration macro: ALU_ISSUE_FWD_EN
//   defined   : rs1/rs2 values are forwarded from EX (priority) then WB
//   undefined : no forwarding logic, fwd_* signals are ignored
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    localparam logic [3:0] FUNC_ZERO = 4'd0;
    localparam logic [3:0] FUNC_ADD  = 4'd1;
    localparam logic [3:0] FUNC_SUB  = 4'd2;
    localparam logic [3:0] FUNC_SLL  = 4'd3;
    localparam logic [3:0] FUNC_SLT  = 4'd4;
    localparam logic [3:0] FUNC_XOR  = 4'd5;
    localparam logic [3:0] FUNC_OR   = 4'd6;
    localparam logic [3:0] FUNC_AND  = 4'd7;
    localparam logic [3:0] FUNC_SRL  = 4'd8;
    localparam logic [3:0] FUNC_SRA  = 4'd9;
    localparam logic [3:0] FUNC_SLTU = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [DataWidth-1:0]    DATA_ZERO = {DataWidth{1'b0}};
    localparam logic [RegAddrWidth-1:0] IDX_ZERO  = {RegAddrWidth{1'b0}};
    localparam logic [DataWidth-1:0]    LINK_STEP = DataWidth'(32'd4);

    // Register-register / register-immediate funct3 mapping. The immediate
    // form never subtracts: bit 30 of an I-type is part of the immediate,
    // except for SRAI where it selects the arithmetic shift.
    function automatic logic [3:0] arith_func(input logic [2:0] f3,
                                              input logic       f7_5,
                                              input logic       is_imm);
        logic [3:0] f;
        case (f3)
            3'b000:  f = (f7_5 && !is_imm) ? FUNC_SUB : FUNC_ADD;
            3'b001:  f = FUNC_SLL;
            3'b010:  f = FUNC_SLT;
            3'b011:  f = FUNC_SLTU;
            3'b100:  f = FUNC_XOR;
            3'b101:  f = f7_5 ? FUNC_SRA : FUNC_SRL;
            3'b110:  f = FUNC_OR;
            3'b111:  f = FUNC_AND;
            default: f = FUNC_ZERO;
        endcase
        return f;
    endfunction

`ifdef ALU_ISSUE_FWD_EN
    // Newest producer wins: EX/MEM result beats MEM/WB, which beats the
    // register file. x0 is hard-wired to zero whatever the sources claim.
    function automatic logic [DataWidth-1:0] fwd_pick(
        input logic [RegAddrWidth-1:0] idx,
        input logic [DataWidth-1:0]    rf_data,
        input logic                    ex_valid,
        input logic [RegAddrWidth-1:0] ex_rd,
        input logic [DataWidth-1:0]    ex_data,
        input logic                    wb_valid,
        input logic [RegAddrWidth-1:0] wb_rd,
        input logic [DataWidth-1:0]    wb_data);
        logic [DataWidth-1:0] v;
        if (idx == IDX_ZERO) begin
            v = DATA_ZERO;
        end else if (ex_valid && (ex_rd == idx)) begin
            v = ex_data;
        end else if (wb_valid && (wb_rd == idx)) begin
            v = wb_data;
        end else begin
            v = rf_data;
        end
        return v;
    endfunction
`endif

    logic [DataWidth-1:0]    rs1_val_s;
    logic [DataWidth-1:0]    rs2_val_s;
    logic [3:0]              func_s;
    logic [DataWidth-1:0]    op1_s;
    logic [DataWidth-1:0]    op2_s;
    logic                    illegal_s;
    logic                    rd_kill_s;
    logic                    accept_s;

    logic                    out_valid_r;
    logic [3:0]              alu_func_r;
    logic [DataWidth-1:0]    alu_op1_r;
    logic [DataWidth-1:0]    alu_op2_r;
    logic [RegAddrWidth-1:0] rd_out_r;
    logic [DataWidth-1:0]    rs2_fwd_out_r;
    logic                    illegal_r;

`ifdef ALU_ISSUE_FWD_EN
    assign rs1_val_s = fwd_pick(bus.rs1_idx, bus.rs1_data,
                                bus.fwd_ex_valid, bus.fwd_ex_rd, bus.fwd_ex_data,
                                bus.fwd_wb_valid, bus.fwd_wb_rd, bus.fwd_wb_data);
    assign rs2_val_s = fwd_pick(bus.rs2_idx, bus.rs2_data,
                                bus.fwd_ex_valid, bus.fwd_ex_rd, bus.fwd_ex_data,
                                bus.fwd_wb_valid, bus.fwd_wb_rd, bus.fwd_wb_data);
`else
    assign rs1_val_s = (bus.rs1_idx == IDX_ZERO) ? DATA_ZERO : bus.rs1_data;
    assign rs2_val_s = (bus.rs2_idx == IDX_ZERO) ? DATA_ZERO : bus.rs2_data;

    // Forwarding inputs remain in the port list but have no consumer here.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{bus.fwd_ex_valid, bus.fwd_ex_rd, bus.fwd_ex_data,
                            bus.fwd_wb_valid, bus.fwd_wb_rd, bus.fwd_wb_data};
`endif

    // A slot is free when empty or when the consumer drains it this cycle.
    assign bus.in_ready = !out_valid_r || bus.out_ready;
    assign accept_s     = bus.in_valid && bus.in_ready;

    // Opcode decode: ALU function code, operand selection, illegal flag and
    // whether the instruction writes no destination register.
    always_comb begin
        func_s    = FUNC_ZERO;
        op1_s     = DATA_ZERO;
        op2_s     = DATA_ZERO;
        illegal_s = 1'b0;
        rd_kill_s = 1'b0;
        case (bus.opcode)
            OPC_OP: begin
                op1_s  = rs1_val_s;
                op2_s  = rs2_val_s;
                func_s = arith_func(bus.funct3, bus.funct7_5, 1'b0);
            end
            OPC_OP_IMM: begin
                op1_s  = rs1_val_s;
                op2_s  = bus.imm;
                func_s = arith_func(bus.funct3, bus.funct7_5, 1'b1);
            end
            OPC_LUI: begin
                op2_s  = bus.imm;
                func_s = FUNC_ADD;
            end
            OPC_AUIPC: begin
                op1_s  = bus.pc;
                op2_s  = bus.imm;
                func_s = FUNC_ADD;
            end
            OPC_LOAD: begin
                op1_s  = rs1_val_s;
                op2_s  = bus.imm;
                func_s = FUNC_ADD;
            end
            OPC_STORE: begin
                op1_s     = rs1_val_s;
                op2_s     = bus.imm;
                func_s    = FUNC_ADD;
                rd_kill_s = 1'b1;
            end
            OPC_BRANCH: begin
                op1_s     = rs1_val_s;
                op2_s     = rs2_val_s;
                rd_kill_s = 1'b1;
                // funct3[0] only distinguishes the sense of the comparison.
                case (bus.funct3[2:1])
                    2'b00:   func_s = FUNC_SUB;
                    2'b10:   func_s = FUNC_SLT;
                    2'b11:   func_s = FUNC_SLTU;
                    default: begin
                        func_s    = FUNC_ZERO;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                op1_s  = bus.pc;
                op2_s  = LINK_STEP;
                func_s = FUNC_ADD;
            end
            default: begin
                illegal_s = 1'b1;
                rd_kill_s = 1'b1;
            end
        endcase
    end

    // Pipeline register: flush kills everything, otherwise capture on
    // accept, drain when the consumer takes the held entry, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            alu_func_r    <= FUNC_ZERO;
            alu_op1_r     <= DATA_ZERO;
            alu_op2_r     <= DATA_ZERO;
            rd_out_r      <= IDX_ZERO;
            rs2_fwd_out_r <= DATA_ZERO;
            illegal_r     <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            alu_func_r    <= func_s;
            alu_op1_r     <= op1_s;
            alu_op2_r     <= op2_s;
            rd_out_r      <= rd_kill_s ? IDX_ZERO : bus.rd_idx;
            rs2_fwd_out_r <= rs2_val_s;
            illegal_r     <= illegal_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.alu_func    = alu_func_r;
    assign bus.alu_op1     = alu_op1_r;
    assign bus.alu_op2     = alu_op2_r;
    assign bus.rd_out      = rd_out_r;
    assign bus.rs2_fwd_out = rs2_fwd_out_r;
    assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage: a spec-level reference model is
// compared against the DUT on every falling edge, and directed vectors pin
// hand-computed literal values (decode, forwarding, stall, flush, reset).
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    bit   run_chk;

    alu_issue_if #(.DataWidth(32), .RegAddrWidth(5)) bus ();

    alu_issue_stage #(.DataWidth(32), .RegAddrWidth(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  func;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic [31:0] rs2;
        logic        ill;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value of a source register as the instruction sees it.
    function automatic logic [31:0] ref_src(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_FWD_EN
        if (bus.fwd_ex_valid && bus.fwd_ex_rd == idx) return bus.fwd_ex_data;
        if (bus.fwd_wb_valid && bus.fwd_wb_rd == idx) return bus.fwd_wb_data;
`endif
        return rf;
    endfunction

    // What the ALU must be told for the instruction currently on the inputs.
    function automatic exp_t ref_model();
        exp_t e;
        logic [3:0]  op_tab [8];
        logic [3:0]  br_tab [4];
        logic [31:0] a;
        op_tab = '{4'd1, 4'd3, 4'd4, 4'd10, 4'd5, 4'd8, 4'd6, 4'd7};
        br_tab = '{4'd2, 4'd0, 4'd4, 4'd10};
        e      = '0;
        a      = ref_src(bus.rs1_idx, bus.rs1_data);
        e.rs2  = ref_src(bus.rs2_idx, bus.rs2_data);
        e.rd   = bus.rd_idx;
        case (bus.opcode)
            7'h33: begin
                e.op1 = a; e.op2 = e.rs2; e.func = op_tab[bus.funct3];
                if (bus.funct7_5 && bus.funct3 == 3'd0) e.func = 4'd2;
                if (bus.funct7_5 && bus.funct3 == 3'd5) e.func = 4'd9;
            end
            7'h13: begin
                e.op1 = a; e.op2 = bus.imm; e.func = op_tab[bus.funct3];
                if (bus.funct7_5 && bus.funct3 == 3'd5) e.func = 4'd9;
            end
            7'h37: begin e.op2 = bus.imm; e.func = 4'd1; end
            7'h17: begin e.op1 = bus.pc; e.op2 = bus.imm; e.func = 4'd1; end
            7'h03: begin e.op1 = a; e.op2 = bus.imm; e.func = 4'd1; end
            7'h23: begin e.op1 = a; e.op2 = bus.imm; e.func = 4'd1; e.rd = 5'd0; end
            7'h63: begin
                e.op1 = a; e.op2 = e.rs2; e.rd = 5'd0;
                e.func = br_tab[bus.funct3 / 3'd2];
                e.ill  = (bus.funct3 / 3'd2 == 3'd1);
            end
            7'h6f, 7'h67: begin e.op1 = bus.pc; e.op2 = 32'd4; e.func = 4'd1; end
            default: begin e.ill = 1'b1; e.rd = 5'd0; end
        endcase
        return e;
    endfunction

    // Reference model of the one-entry output slot.
    logic m_valid;
    exp_t m_q;
    logic m_accept;
    assign m_accept = bus.in_valid && (!m_valid || bus.out_ready);

    // Slot occupancy and contents as the specification defines them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_q     <= '0;
        end else begin
            m_valid <= !bus.flush && (m_accept || (m_valid && !bus.out_ready));
            if (m_accept && !bus.flush) m_q <= ref_model();
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("m_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            if (m_valid) begin
                chk("m_alu_func", 32'(bus.alu_func), 32'(m_q.func));
                chk("m_alu_op1", bus.alu_op1, m_q.op1);
                chk("m_alu_op2", bus.alu_op2, m_q.op2);
                chk("m_rd_out", 32'(bus.rd_out), 32'(m_q.rd));
                chk("m_rs2_fwd", bus.rs2_fwd_out, m_q.rs2);
                chk("m_illegal", 32'(bus.illegal), 32'(m_q.ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] immv, input logic [31:0] pcv);
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
        bus.rs1_idx  = r1;
        bus.rs2_idx  = r2;
        bus.rd_idx   = rd;
        bus.rs1_data = d1;
        bus.rs2_data = d2;
        bus.imm      = immv;
        bus.pc       = pcv;
    endtask

    task automatic set_fwd(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                           input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd);
        bus.fwd_ex_valid = exv;
        bus.fwd_ex_rd    = exrd;
        bus.fwd_ex_data  = exd;
        bus.fwd_wb_valid = wbv;
        bus.fwd_wb_rd    = wbrd;
        bus.fwd_wb_data  = wbd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_alu_func"}, 32'(bus.alu_func), 32'd0);
        chk({tag, "_alu_op1"}, bus.alu_op1, 32'd0);
        chk({tag, "_alu_op2"}, bus.alu_op2, 32'd0);
        chk({tag, "_rd_out"}, 32'(bus.rd_out), 32'd0);
        chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    logic [6:0] opc_list [11];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        run_chk      = 1'b0;
        rst_n        = 1'b0;
        opc_list = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h7f, 7'h0b};
        set_instr(7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        chk_all_zero("reset");
        rst_n   = 1'b1;
        run_chk = 1'b1;
        step();

        // SRA register-register
        set_instr(7'b0110011, 3'b101, 1'b1, 5'd1, 5'd2, 5'd5, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        step();
        chk("sra_valid", 32'(bus.out_valid), 32'd1);
        chk("sra_func", 32'(bus.alu_func), 32'd9);
        chk("sra_op1", bus.alu_op1, 32'h8000_0000);
        chk("sra_op2", bus.alu_op2, 32'd4);
        chk("sra_rd", 32'(bus.rd_out), 32'd5);

        // OP-IMM 000 with bit 30 set is still ADD
        set_instr(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd0, 5'd6, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0);
        step();
        chk("addi_func", 32'(bus.alu_func), 32'd1);
        chk("addi_op2", bus.alu_op2, 32'hFFFF_FFFF);

        // AUIPC
        set_instr(7'b0010111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h2000, 32'h100);
        step();
        chk("auipc_op1", bus.alu_op1, 32'h100);
        chk("auipc_op2", bus.alu_op2, 32'h2000);
        chk("auipc_func", 32'(bus.alu_func), 32'd1);

        // Forwarding: EX beats WB
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd3, 5'd0, 5'd8, 32'h11, 32'd0, 32'd0, 32'd0);
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_ex_op1", bus.alu_op1, 32'hAA);
`else
        chk("nofwd_op1", bus.alu_op1, 32'h11);
`endif
        // x0 never forwarded
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8, 32'h55, 32'd0, 32'd0, 32'd0);
        step();
        chk("x0_op1", bus.alu_op1, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Stall: hold outputs for three cycles, then resume without bubble
        set_instr(7'b0110111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h1234_5000, 32'd0);
        step();
        bus.out_ready = 1'b0;
        set_instr(7'b0110011, 3'b100, 1'b0, 5'd1, 5'd2, 5'd9, 32'hF0, 32'h0F, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_op2", bus.alu_op2, 32'h1234_5000);
            chk("stall_func", 32'(bus.alu_func), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("resume_func", 32'(bus.alu_func), 32'd5);
        chk("resume_rd", 32'(bus.rd_out), 32'd9);
        set_instr(7'b0110011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd10, 32'hF0, 32'h3C, 32'd0, 32'd0);
        step();
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_func", 32'(bus.alu_func), 32'd7);

        // Flush together with an accepted instruction
        bus.flush = 1'b1;
        set_instr(7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 32'd0, 32'd0);
        step();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;

        // Unknown opcode flows as an illegal bubble
        set_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        chk("ill_valid", 32'(bus.out_valid), 32'd1);
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        chk("ill_func", 32'(bus.alu_func), 32'd0);
        chk("ill_rd", 32'(bus.rd_out), 32'd0);

        // JAL link value and store rd suppression
        set_instr(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 32'h400);
        step();
        chk("jal_op1", bus.alu_op1, 32'h400);
        chk("jal_op2", bus.alu_op2, 32'd4);
        set_instr(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd12, 32'h40, 32'hDEAD, 32'h8, 32'd0);
        step();
        chk("store_rd", 32'(bus.rd_out), 32'd0);
        chk("store_rs2", bus.rs2_fwd_out, 32'hDEAD);

        // Directed opcode table with varied data, forwarding and back-pressure
        for (int i = 0; i < 66; i++) begin
            set_instr(opc_list[i % 11], 3'(i % 8), 1'(i / 11), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                      $urandom, $urandom);
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            bus.flush     = 1'(i % 17 == 16);
            step();
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Mid-stream asynchronous reset with a valid entry held
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 32'd0, 32'd0);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.in_valid = 1'b0;
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) step();

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
